io_uart: RTL and testbench

Memory-mapped UART transmitter on the softcore's I/O port, directly downstream of `mmu`. It consumes `io_addr`, `io_en`, `io_we` and `io_data_write`, and drives `io_data_read` back into `mmu`. Bytes written by the core go into a small TX FIFO and are serialised on `uart_tx` as 8N1 frames at a programmable bit period. Status and divisor registers are readable through the same port with one-cycle read latency.

---
 rtl/io_uart_pkg.sv | 33 +++
 rtl/io_uart_fifo.sv | 50 +++++
 rtl/io_uart.sv | 168 ++++++++++++++++
 tb/tb_io_uart.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_uart_pkg.sv
// io_uart_pkg: register map, STATUS bit positions and TX FSM encodings for io_uart.
// Shared by the UART top, its FIFO and anything on the mmu side that talks to it.
// The optional parity feature is selected with `define IO_UART_PARITY_EN.
`timescale 1ns/1ps
package io_uart_pkg;

  // I/O word addresses as seen on io_addr
  localparam logic [7:0] IO_UART_TXDATA  = 8'h00;
  localparam logic [7:0] IO_UART_STATUS  = 8'h01;
  localparam logic [7:0] IO_UART_BAUDDIV = 8'h02;

  // STATUS bit positions
  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_BUSY   = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_PARITY = 4;

  // TX FSM encodings; TX_PARITY is only reachable when parity is compiled in
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // Even parity: the bit that makes the total number of ones even
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/io_uart_fifo.sv
// io_uart_fifo: generic synchronous FIFO with extra-MSB pointers for full/empty detection.
// Output dout is combinational from the read pointer (first-word fall-through).
// Push while full and pop while empty are ignored; push and pop together keep the count.
`timescale 1ns/1ps
module io_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Pointers wrap naturally modulo 2*DEPTH; the MSB distinguishes full from empty
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards any queued contents
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/io_uart.sv
// io_uart: memory-mapped UART transmitter (8N1, or 8E1 when `define IO_UART_PARITY_EN).
// Latency: register reads return one cycle after the strobe; first start bit one cycle after a TXDATA write.
// Backpressure: none on the bus; TXDATA writes into a full FIFO are dropped and set sticky overflow.
`timescale 1ns/1ps
module io_uart
  import io_uart_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int DEFAULT_BAUDDIV = 867
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [7:0]  io_addr,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [31:0] io_data_write,
  output logic [31:0] io_data_read,
  output logic        uart_tx
);

  localparam logic [15:0] BAUD_RST = 16'(DEFAULT_BAUDDIV);

`ifdef IO_UART_PARITY_EN
  localparam logic PARITY_PRESENT = 1'b1;
`else
  localparam logic PARITY_PRESENT = 1'b0;
`endif

  tx_state_t   state;
  tx_state_t   state_nxt;
  logic [15:0] baud;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        overflow;
  logic        busy;
  logic        bit_end;
  logic        wr_txdata;
  logic        wr_status;
  logic        wr_baud;
  logic        rd_en;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic [31:0] status_word;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  assign wr_txdata = io_en && io_we && (io_addr == IO_UART_TXDATA);
  assign wr_status = io_en && io_we && (io_addr == IO_UART_STATUS);
  assign wr_baud   = io_en && io_we && (io_addr == IO_UART_BAUDDIV);
  assign rd_en     = io_en && !io_we;

  // Full is the pre-edge value, so a same-cycle pop never rescues a write into a full FIFO
  assign fifo_push    = wr_txdata && !fifo_full;
  assign bit_end      = (bit_cnt == 16'd0);
  assign unused_wdata = ^io_data_write[31:16];

  // Pop when idle with data waiting, or at the end of STOP to chain frames without a gap
  assign fifo_pop = !fifo_empty &&
                    ((state == TX_IDLE) || ((state == TX_STOP) && bit_end));

  io_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .resetb (resetb),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (io_data_write[7:0]),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // STATUS as seen at the sampling edge
  always_comb begin
    status_word            = 32'd0;
    status_word[ST_FULL]   = fifo_full;
    status_word[ST_EMPTY]  = fifo_empty;
    status_word[ST_BUSY]   = busy;
    status_word[ST_OVF]    = overflow;
    status_word[ST_PARITY] = PARITY_PRESENT;
  end

  // Read mux; unmapped and write-only addresses read as zero
  always_comb begin
    rd_mux = 32'd0;
    case (io_addr)
      IO_UART_STATUS:  rd_mux = status_word;
      IO_UART_BAUDDIV: rd_mux = {16'd0, baud};
      default:         rd_mux = 32'd0;
    endcase
  end

  // Bus-side registers: divisor, sticky overflow, and the held read data
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      baud         <= BAUD_RST;
      overflow     <= 1'b0;
      io_data_read <= 32'd0;
    end else begin
      if (wr_baud) baud <= io_data_write[15:0];
      if (wr_txdata && fifo_full) overflow <= 1'b1;
      else if (wr_status)         overflow <= 1'b0;
      if (rd_en) io_data_read <= rd_mux;
    end
  end

  // TX FSM state register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= TX_IDLE;
    else         state <= state_nxt;
  end

  // TX FSM next-state logic; every non-idle state lasts one bit period
  always_comb begin
    state_nxt = state;
    case (state)
      TX_IDLE:  if (!fifo_empty) state_nxt = TX_START;
      TX_START: if (bit_end) state_nxt = TX_DATA;
`ifdef IO_UART_PARITY_EN
      TX_DATA:   if (bit_end && (bit_idx == 3'd7)) state_nxt = TX_PARITY;
      TX_PARITY: if (bit_end) state_nxt = TX_STOP;
`else
      TX_DATA:  if (bit_end && (bit_idx == 3'd7)) state_nxt = TX_STOP;
`endif
      TX_STOP:  if (bit_end) state_nxt = fifo_empty ? TX_IDLE : TX_START;
      default:  state_nxt = TX_IDLE;
    endcase
  end

  // TX FSM outputs: line level is decoded from state so reset forces it high at once
  always_comb begin
    uart_tx = 1'b1;
    busy    = (state != TX_IDLE);
    case (state)
      TX_START:  uart_tx = 1'b0;
      TX_DATA:   uart_tx = shreg[bit_idx];
`ifdef IO_UART_PARITY_EN
      TX_PARITY: uart_tx = even_parity(shreg);
`endif
      default:   uart_tx = 1'b1;
    endcase
  end

  // Bit timer, data bit index and shift register; the divisor is sampled only at bit starts
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      bit_cnt <= 16'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
    end else begin
      if (fifo_pop) begin
        shreg   <= fifo_dout;
        bit_idx <= 3'd0;
      end else if ((state == TX_DATA) && bit_end) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (fifo_pop || ((state != TX_IDLE) && bit_end)) bit_cnt <= baud;
      else if (state != TX_IDLE)                        bit_cnt <= bit_cnt - 16'd1;
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// tb_io_uart: table-driven register checks, directed frame/timing sequences and a random phase.
// A line monitor decodes uart_tx against a queue of accepted bytes and the current bit period.
// FIFO occupancy, busy and overflow are predicted from accepted bytes versus frames seen on the line.
`timescale 1ns/1ps
module tb_io_uart;

  localparam int DEPTH = 4;
`ifdef IO_UART_PARITY_EN
  localparam int   NBITS = 11;
  localparam logic PAR   = 1'b1;
`else
  localparam int   NBITS = 10;
  localparam logic PAR   = 1'b0;
`endif
  localparam logic [31:0] PST = {27'd0, PAR, 4'd0};

  logic        clk_tb = 1'b0;
  logic        resetb;
  logic [7:0]  io_addr;
  logic        io_en;
  logic        io_we;
  logic [31:0] io_data_write;
  logic [31:0] io_data_read;
  logic        uart_tx;

  io_uart #(.FIFO_DEPTH(DEPTH), .DEFAULT_BAUDDIV(867)) dut (
    .clk           (clk_tb),
    .resetb        (resetb),
    .io_addr       (io_addr),
    .io_en         (io_en),
    .io_we         (io_we),
    .io_data_write (io_data_write),
    .io_data_read  (io_data_read),
    .uart_tx       (uart_tx)
  );

  always #5 clk_tb = ~clk_tb;

  int cyc = 0;
  always @(posedge clk_tb) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  int         starts_q[$];
  int         acc = 0;
  int         started = 0;
  logic       ovf_m = 1'b0;
  int         baud_m = 867;
  logic       mon_busy = 1'b0;
  int         last_end = 0;
  logic [10:0] last_bits = '0;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int n;
    n = acc - started;
    case (a)
      8'h01:   return {27'd0, PAR, ovf_m, mon_busy, (n == 0), (n == DEPTH)};
      8'h02:   return 32'(baud_m[15:0]);
      default: return 32'd0;
    endcase
  endfunction

  // Bus write; the model follows at the sampling edge
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    io_en = 1'b1; io_we = 1'b1; io_addr = a; io_data_write = d;
    @(posedge clk_tb);
    if (a == 8'h00) begin
      if (acc - started == DEPTH) ovf_m = 1'b1;
      else begin
        acc++;
        exp_q.push_back(d[7:0]);
      end
    end else if (a == 8'h01) begin
      ovf_m = 1'b0;
    end else if (a == 8'h02) begin
      baud_m = int'(d[15:0]);
    end
    @(negedge clk_tb);
    io_en = 1'b0; io_we = 1'b0;
  endtask

  // Bus read; returns the DUT data and the model's prediction at the sampling edge
  task automatic rd(input logic [7:0] a, output logic [31:0] act, output logic [31:0] mdl);
    io_en = 1'b1; io_we = 1'b0; io_addr = a;
    @(posedge clk_tb);
    mdl = model_read(a);
    @(negedge clk_tb);
    io_en = 1'b0;
    act = io_data_read;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk_tb);
  endtask

  task automatic wait_start(output int s);
    int n = 0;
    while (starts_q.size() == 0 && n < 2000) begin
      @(negedge clk_tb);
      n++;
    end
    if (starts_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL wait_start: no start bit within 2000 cycles");
      s = cyc;
    end else begin
      s = starts_q[0];
    end
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy || acc != started) && n < limit) begin
      @(negedge clk_tb);
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL drain: %0d bytes still pending after %0d cycles, required 0", exp_q.size(), limit);
    end
    repeat (3) @(negedge clk_tb);
  endtask

  // Line monitor: each frame must match the queued byte with every bit exactly one period long
  initial begin : monitor
    logic [10:0] exp_bits;
    logic [7:0]  b;
    int k, j, period, bad;
    logic in_frame;
    in_frame = 1'b0; k = 0; j = 0; period = 1; bad = 0; b = 8'h00; exp_bits = '1;
    forever begin
      @(negedge clk_tb);
      if (resetb !== 1'b1) begin
        in_frame = 1'b0;
        mon_busy = 1'b0;
      end else begin
        if (!in_frame) begin
          if (uart_tx === 1'b0) begin
            in_frame = 1'b1;
            mon_busy = 1'b1;
            started++;
            starts_q.push_back(cyc);
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_frame: start bit at cycle %0d with no byte queued", cyc);
              b = 8'h00;
            end else begin
              b = exp_q.pop_front();
            end
            exp_bits = '1;
            exp_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
            if (NBITS == 11) exp_bits[9] = ^b;
            k = 0; j = 0; bad = 0;
            period = baud_m + 1;
          end else begin
            mon_busy = 1'b0;
          end
        end
        if (in_frame) begin
          if (j == 0) last_bits[k] = uart_tx;
          if (uart_tx !== exp_bits[k]) bad++;
          j++;
          if (j == period) begin
            j = 0;
            k++;
            if (k == NBITS) begin
              in_frame = 1'b0;
              last_end = cyc;
              checks++;
              if (bad != 0) begin
                errors++;
                $display("FAIL frame: byte 0x%02h had %0d wrong line cycles, required 0", b, bad);
              end
            end else begin
              period = baud_m + 1;
            end
          end
        end
      end
    end
  end

  initial begin : main
    vec_t tbl [13];
    logic [31:0] act, mdl;
    int e, s;

    tbl[0]  = '{1'b0, 8'h01, 32'h0,         32'h2 | PST};
    tbl[1]  = '{1'b0, 8'h02, 32'h0,         32'd867};
    tbl[2]  = '{1'b0, 8'h00, 32'h0,         32'h0};
    tbl[3]  = '{1'b0, 8'h03, 32'h0,         32'h0};
    tbl[4]  = '{1'b0, 8'hFF, 32'h0,         32'h0};
    tbl[5]  = '{1'b1, 8'h02, 32'hFFFF_1234, 32'h0};
    tbl[6]  = '{1'b0, 8'h02, 32'h0,         32'h1234};
    tbl[7]  = '{1'b1, 8'h09, 32'h55,        32'h1234};
    tbl[8]  = '{1'b0, 8'h02, 32'h0,         32'h1234};
    tbl[9]  = '{1'b1, 8'h01, 32'h0,         32'h1234};
    tbl[10] = '{1'b0, 8'h01, 32'h0,         32'h2 | PST};
    tbl[11] = '{1'b1, 8'h02, 32'h3,         32'h2 | PST};
    tbl[12] = '{1'b0, 8'h02, 32'h0,         32'h3};

    resetb = 1'b0; io_en = 1'b0; io_we = 1'b0; io_addr = 8'h00; io_data_write = 32'h0;
    repeat (3) @(negedge clk_tb);
    chk("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    chk("reset_io_data_read", io_data_read, 32'd0);
    resetb = 1'b1;
    @(negedge clk_tb);

    // Register map; on write rows the read data must hold the previous read value
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].we) begin
        wr(tbl[i].addr, tbl[i].wdata);
        chk($sformatf("table[%0d]_held", i), io_data_read, tbl[i].exp);
      end else begin
        rd(tbl[i].addr, act, mdl);
        chk($sformatf("table[%0d]", i), act, tbl[i].exp);
      end
    end
    chk("idle_line", {31'd0, uart_tx}, 32'd1);

    // Single frame 0xA5 at 4 clocks per bit
    starts_q.delete();
    wr(8'h00, 32'h0000_00A5);
    e = cyc;
    rd(8'h01, act, mdl);
    chk("status_pre_pop", act, 32'h0 | PST);
    rd(8'h01, act, mdl);
    chk("status_busy", act, 32'h6 | PST);
    wait_cyc(e + 40);
    rd(8'h01, act, mdl);
    chk("status_last_stop", act, 32'h6 | PST);
    rd(8'h01, act, mdl);
    chk("status_after_frame", act, 32'h2 | PST);
    chk("first_start_edge", starts_q[0], e + 1);
    chk("a5_frame_len", last_end - starts_q[0] + 1, 32'(NBITS * 4));

    // Four back-to-back frames at 2 clocks per bit
    wr(8'h02, 32'd1);
    starts_q.delete();
    wr(8'h00, 32'h11);
    e = cyc;
    wr(8'h00, 32'h22);
    wr(8'h00, 32'h33);
    wr(8'h00, 32'h44);
    rd(8'h01, act, mdl);
    chk("b2b_status", act, 32'h4 | PST);
    chk("b2b_status_model", act, mdl);
    drain(2000);
    chk("b2b_frames", starts_q.size(), 32'd4);
    chk("b2b_first_start", starts_q[0], e + 1);
    for (int i = 0; i < 3 && i + 1 < starts_q.size(); i++)
      chk($sformatf("b2b_gap[%0d]", i), starts_q[i+1] - starts_q[i], 32'(NBITS * 2));

    // Overflow: one byte in flight plus four queued, the sixth is dropped
    wr(8'h02, 32'd100);
    for (int i = 1; i <= 6; i++) wr(8'h00, 32'(i));
    rd(8'h01, act, mdl);
    chk("ovf_status", act, 32'hD | PST);
    chk("ovf_status_model", act, mdl);
    wr(8'h01, 32'h0);
    rd(8'h01, act, mdl);
    chk("ovf_cleared", act, 32'h5 | PST);
    drain(20000);
    repeat (20) @(negedge clk_tb);
    chk("ovf_byte_not_sent", started, acc);

    // Divisor change in the middle of data bit 3
    wr(8'h02, 32'd3);
    starts_q.delete();
    wr(8'h00, 32'h5A);
    wait_start(s);
    wait_cyc(s + 17);
    wr(8'h02, 32'd7);
    drain(2000);
    chk("midbaud_frame_len", last_end - s + 1, 32'(20 + (NBITS - 5) * 8));

    // Parity/length check for 0x07
    wr(8'h02, 32'd3);
    starts_q.delete();
    wr(8'h00, 32'h07);
    wait_start(s);
    drain(2000);
    chk("x07_frame_len", last_end - s + 1, 32'(NBITS * 4));
`ifdef IO_UART_PARITY_EN
    chk("x07_parity_bit", {31'd0, last_bits[9]}, 32'd1);
`endif

    // Reset in the middle of a data bit
    starts_q.delete();
    wr(8'h00, 32'hF0);
    wait_start(s);
    wait_cyc(s + 9);
    chk("tx_low_before_reset", {31'd0, uart_tx}, 32'd0);
    #2 resetb = 1'b0;
    #1 chk("tx_async_reset", {31'd0, uart_tx}, 32'd1);
    @(negedge clk_tb);
    #1;
    exp_q.delete(); acc = 0; started = 0; ovf_m = 1'b0; baud_m = 867;
    #1 resetb = 1'b1;
    @(negedge clk_tb);
    rd(8'h01, act, mdl);
    chk("status_after_reset", act, 32'h2 | PST);
    rd(8'h02, act, mdl);
    chk("baud_after_reset", act, 32'd867);

    // Random traffic against the model
    for (int r = 0; r < 4; r++) begin
      wr(8'h02, 32'($urandom_range(0, 3)));
      for (int n = 0; n < 60; n++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: wr(8'h00, 32'($urandom));
          5, 6, 7: begin
            rd(8'h01, act, mdl);
            chk("rand_status", act, mdl);
          end
          8: begin
            rd(8'h02, act, mdl);
            chk("rand_baud", act, mdl);
          end
          default: wr(8'h01, 32'h0);
        endcase
      end
      drain(5000);
      rd(8'h01, act, mdl);
      chk("rand_status_drained", act, mdl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
